// File: rtl/branch_pred_ctrl.sv
// Write-port owner for the BHT/PHT predictor: sequential table clear, resolved-branch
// updates, mispredict redirect and saturating branch statistics.
module branch_pred_ctrl #(
  parameter int         BHT_WIDTH = 10,
  parameter int         PHT_WIDTH = 4,
  parameter logic [1:0] PHT_INIT  = 2'b10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_req,
  input  logic                 branch_M,
  input  logic                 stall_M,
  input  logic                 pred_take_M,
  input  logic                 actual_take_M,
  input  logic [31:0]          pc_M,
  input  logic [31:0]          target_M,
  input  logic [PHT_WIDTH-1:0] bht_rdata,
  input  logic [1:0]           pht_rdata,
  output logic [BHT_WIDTH-1:0] bht_raddr,
  output logic                 bht_we,
  output logic [BHT_WIDTH-1:0] bht_waddr,
  output logic [PHT_WIDTH-1:0] bht_wdata,
  output logic                 pht_we,
  output logic [PHT_WIDTH-1:0] pht_waddr,
  output logic [1:0]           pht_wdata,
  output logic                 pred_en,
  output logic                 busy,
  output logic                 mispredict_M,
  output logic [31:0]          redirect_pc,
  output logic [31:0]          branch_cnt,
  output logic [31:0]          mispred_cnt
);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  localparam logic [BHT_WIDTH-1:0] IDX_LAST = '1;
  localparam logic [BHT_WIDTH-1:0] IDX_ONE  = BHT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [BHT_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]          branch_cnt_q, branch_cnt_d;
  logic [31:0]          mispred_cnt_q, mispred_cnt_d;
  logic                 upd;

  function automatic logic [1:0] pht_next(input logic [1:0] cur, input logic taken);
    if (taken) return (cur == 2'b11) ? 2'b11 : cur + 2'd1;
    else       return (cur == 2'b00) ? 2'b00 : cur - 2'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign bht_raddr   = pc_M[BHT_WIDTH+1:2];
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bht_we        = 1'b0;
    bht_waddr     = '0;
    bht_wdata     = '0;
    pht_we        = 1'b0;
    pht_waddr     = '0;
    pht_wdata     = 2'b00;
    busy          = 1'b1;
    pred_en       = 1'b0;
    redirect_pc   = 32'd0;
    // A branch held in M counts once, on the cycle it finally leaves.
    upd           = branch_M & ~stall_M & ~rst;
    mispredict_M  = upd & (pred_take_M ^ actual_take_M);
    if (mispredict_M) redirect_pc = actual_take_M ? target_M : pc_M + 32'd8;

    case (state_q)
      S_CLEAR: begin
        bht_we    = 1'b1;
        bht_waddr = idx_q;
        if (idx_q[BHT_WIDTH-1:PHT_WIDTH] == '0) begin
          pht_we    = 1'b1;
          pht_waddr = idx_q[PHT_WIDTH-1:0];
          pht_wdata = PHT_INIT;
        end
        if (clear_req) begin
          idx_d = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      default: begin
        busy    = 1'b0;
        pred_en = 1'b1;
        if (upd) begin
          bht_we    = 1'b1;
          bht_waddr = bht_raddr;
          bht_wdata = {bht_rdata[PHT_WIDTH-2:0], actual_take_M};
          pht_we    = 1'b1;
          pht_waddr = bht_rdata;
          pht_wdata = pht_next(pht_rdata, actual_take_M);
        end
        if (clear_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
    endcase

    // Reset must silence the table ports without waiting for a clock edge.
    if (rst) begin
      bht_we  = 1'b0;
      pht_we  = 1'b0;
      busy    = 1'b1;
      pred_en = 1'b0;
    end

    branch_cnt_d  = upd          ? sat_inc(branch_cnt_q)  : branch_cnt_q;
    mispred_cnt_d = mispredict_M ? sat_inc(mispred_cnt_q) : mispred_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_CLEAR;
      idx_q         <= '0;
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule
